// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle MIPS controller and its ALU-control stage.
// The HALT state exists only when MC_ILLEGAL_TRAP_EN is defined.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_OR    = 3'b001;
  localparam logic [2:0] ALUOP_SLT   = 3'b011;
  localparam logic [2:0] ALUOP_SUB   = 3'b101;
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_BRANCH,
    S_JUMP
`ifdef MC_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  typedef struct packed {
    logic rtype;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic imm_alu;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// Opcode classifier: one-hot instruction class plus the ALU operation used by
// the immediate-ALU instructions in EXEC_I.
module opcode_class_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class,
  output logic [2:0] imm_alu_op
);

  always_comb begin
    op_class   = '0;
    imm_alu_op = ALUOP_ADD;
    case (opcode)
      OP_RTYPE: op_class.rtype  = 1'b1;
      OP_LW:    op_class.load   = 1'b1;
      OP_SW:    op_class.store  = 1'b1;
      OP_BEQ:   op_class.branch = 1'b1;
      OP_J:     op_class.jump   = 1'b1;
      OP_ADDI:  op_class.imm_alu = 1'b1;
      OP_ORI: begin
        op_class.imm_alu = 1'b1;
        imm_alu_op       = ALUOP_OR;
      end
      OP_SLTI: begin
        op_class.imm_alu = 1'b1;
        imm_alu_op       = ALUOP_SLT;
      end
      default:  op_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore multicycle main control for the 32-bit MIPS datapath.
// MC_ILLEGAL_TRAP_EN: illegal opcodes halt and set a sticky illegal_op flag.
//
// state    | meaning
// FETCH    | read instruction, PC+4; waits on mem_ready
// DECODE   | register read, branch target into ALUOut, dispatch
// MEM_ADDR | effective address for lw/sw
// MEM_RD   | data read, waits on mem_ready
// MEM_WB   | load data to rt
// MEM_WR   | data write, waits on mem_ready
// EXEC_R   | R-type ALU operation
// WB_R     | ALU result to rd
// EXEC_I   | immediate ALU operation
// WB_I     | ALU result to rt
// BRANCH   | beq compare and conditional PC update
// JUMP     | PC <- jump target
// HALT     | trapped on illegal opcode, exits only on reset
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic       illegal_op
);

  state_t     state;
  op_class_t  op_class;
  logic [2:0] imm_alu_op;

  opcode_class_decode u_decode (
    .opcode     (opcode),
    .op_class   (op_class),
    .imm_alu_op (imm_alu_op)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          if (op_class.load || op_class.store) state <= S_MEM_ADDR;
          else if (op_class.rtype)             state <= S_EXEC_R;
          else if (op_class.imm_alu)           state <= S_EXEC_I;
          else if (op_class.branch)            state <= S_BRANCH;
          else if (op_class.jump)              state <= S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
          else if (op_class.illegal)           state <= S_HALT;
`else
          else if (op_class.illegal)           state <= S_FETCH;
`endif
          else                                 state <= S_FETCH;
        end
        S_MEM_ADDR: state <= op_class.store ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (mem_ready) state <= S_MEM_WB;
        S_MEM_WR:   if (mem_ready) state <= S_FETCH;
        S_EXEC_R:   state <= S_WB_R;
        S_EXEC_I:   state <= S_WB_I;
`ifdef MC_ILLEGAL_TRAP_EN
        S_HALT:     state <= S_HALT;
`endif
        default:    state <= S_FETCH;
      endcase
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (reset)                                   illegal_q <= 1'b0;
    else if (state == S_DECODE && op_class.illegal) illegal_q <= 1'b1;
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  // Only the FETCH write-enables look at mem_ready; everything else is pure state decode.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_source     = PCSRC_ALU;
    alu_op        = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_RTYPE;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = imm_alu_op;
      end
      S_WB_I:     reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instruction table, random
// instruction stream with random stalls, and reset/trap corner sequences.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    int         fetch_stall;
    int         mem_stall;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;

  int   vectors = 0;
  int   miscompares = 0;
  logic ill_model = 1'b0;
  exp_t act;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010, ADDI = 6'b001000, ORI = 6'b001101, SLTI = 6'b001010;

`ifdef MC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal_op};

  // Expected outputs of each instruction phase, written straight from the phase descriptions.
  function automatic exp_t ph(input string p, input logic rdy = 1'b0, input logic [2:0] aop = 3'b000);
    exp_t e;
    e = '0;
    e.illegal = ill_model;
    case (p)
      "FETCH":  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
      "DECODE": e.alu_src_b = 2'b11;
      "ADDR":   begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      "MRD":    begin e.mem_read = 1; e.i_or_d = 1; end
      "MWB":    begin e.reg_write = 1; e.mem_to_reg = 1; end
      "MWR":    begin e.mem_write = 1; e.i_or_d = 1; end
      "EXR":    begin e.alu_src_a = 1; e.alu_op = 3'b111; end
      "WBR":    begin e.reg_write = 1; e.reg_dst = 1; end
      "EXI":    begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = aop; end
      "WBI":    e.reg_write = 1;
      "BR":     begin e.alu_src_a = 1; e.alu_op = 3'b101; e.pc_write_cond = 1; e.pc_source = 2'b01; end
      "JMP":    begin e.pc_write = 1; e.pc_source = 2'b10; end
      default:  ;
    endcase
    return e;
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rnd_b();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {LW, SW, RT, BEQ, JMP, ADDI, ORI, SLTI};
  endfunction

  task automatic cyc(input logic [5:0] op, input logic rdy, input logic rst, input exp_t e, input string nm);
    @(negedge clk);
    opcode = op;
    mem_ready = rdy;
    reset = rst;
    #1;
    vectors++;
    if (act !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (opcode %b ready %b)", nm, act, e, op, rdy);
    end
  endtask

  // Walks one instruction from FETCH to its last cycle; opcode is only meaningful in the
  // states that sample it, so it is randomised everywhere else.
  task automatic run_instr(input logic [5:0] op, input int sf, input int sm);
    for (int i = 0; i < sf; i++) cyc(rnd_op(), 1'b0, 1'b0, ph("FETCH", 1'b0), "fetch_stall");
    cyc(rnd_op(), 1'b1, 1'b0, ph("FETCH", 1'b1), "fetch");
    cyc(op, rnd_b(), 1'b0, ph("DECODE"), "decode");
    case (op)
      LW: begin
        cyc(op, rnd_b(), 1'b0, ph("ADDR"), "lw_addr");
        for (int i = 0; i < sm; i++) cyc(rnd_op(), 1'b0, 1'b0, ph("MRD"), "lw_rd_stall");
        cyc(rnd_op(), 1'b1, 1'b0, ph("MRD"), "lw_rd");
        cyc(rnd_op(), rnd_b(), 1'b0, ph("MWB"), "lw_wb");
      end
      SW: begin
        cyc(op, rnd_b(), 1'b0, ph("ADDR"), "sw_addr");
        for (int i = 0; i < sm; i++) cyc(rnd_op(), 1'b0, 1'b0, ph("MWR"), "sw_wr_stall");
        cyc(rnd_op(), 1'b1, 1'b0, ph("MWR"), "sw_wr");
      end
      RT: begin
        cyc(rnd_op(), rnd_b(), 1'b0, ph("EXR"), "r_exec");
        cyc(rnd_op(), rnd_b(), 1'b0, ph("WBR"), "r_wb");
      end
      ADDI, ORI, SLTI: begin
        cyc(op, rnd_b(), 1'b0, ph("EXI", 1'b0, (op == ADDI) ? 3'b000 : (op == ORI) ? 3'b001 : 3'b011), "i_exec");
        cyc(rnd_op(), rnd_b(), 1'b0, ph("WBI"), "i_wb");
      end
      BEQ: cyc(rnd_op(), rnd_b(), 1'b0, ph("BR"), "beq");
      JMP: cyc(rnd_op(), rnd_b(), 1'b0, ph("JMP"), "jump");
      default: begin
        if (TRAP) begin
          ill_model = 1'b1;
          for (int i = 0; i < 3; i++) cyc(rnd_op(), rnd_b(), 1'b0, ph("HALT"), "halt");
          cyc(rnd_op(), rnd_b(), 1'b1, ph("HALT"), "halt_reset");
          ill_model = 1'b0;
        end
      end
    endcase
  endtask

  vec_t table_v[12];

  initial begin
    table_v[0]  = '{LW,      0, 0};
    table_v[1]  = '{RT,      0, 0};
    table_v[2]  = '{SW,      0, 3};
    table_v[3]  = '{BEQ,     0, 0};
    table_v[4]  = '{ORI,     0, 0};
    table_v[5]  = '{SLTI,    0, 0};
    table_v[6]  = '{ADDI,    1, 0};
    table_v[7]  = '{JMP,     0, 0};
    table_v[8]  = '{6'h3F,   0, 0};
    table_v[9]  = '{LW,      2, 3};
    table_v[10] = '{6'b010001, 0, 0};
    table_v[11] = '{SW,      1, 0};

    reset = 1'b1;
    repeat (2) @(negedge clk);
    cyc(rnd_op(), 1'b0, 1'b0, ph("FETCH", 1'b0), "reset_fetch");

    foreach (table_v[i]) run_instr(table_v[i].op, table_v[i].fetch_stall, table_v[i].mem_stall);

    // Reset during a stalled load: the load is abandoned, next cycle is FETCH.
    cyc(rnd_op(), 1'b1, 1'b0, ph("FETCH", 1'b1), "fetch");
    cyc(LW, 1'b0, 1'b0, ph("DECODE"), "decode");
    cyc(LW, 1'b0, 1'b0, ph("ADDR"), "lw_addr");
    cyc(rnd_op(), 1'b0, 1'b0, ph("MRD"), "lw_rd_stall");
    cyc(rnd_op(), 1'b0, 1'b1, ph("MRD"), "lw_rd_reset");
    cyc(rnd_op(), 1'b0, 1'b0, ph("FETCH", 1'b0), "after_reset_fetch");

    // Reset during a stalled store.
    cyc(rnd_op(), 1'b1, 1'b0, ph("FETCH", 1'b1), "fetch");
    cyc(SW, 1'b1, 1'b0, ph("DECODE"), "decode");
    cyc(SW, 1'b1, 1'b0, ph("ADDR"), "sw_addr");
    cyc(rnd_op(), 1'b0, 1'b1, ph("MWR"), "sw_wr_reset");
    cyc(rnd_op(), 1'b1, 1'b0, ph("FETCH", 1'b1), "after_reset_fetch");
    cyc(RT, 1'b0, 1'b0, ph("DECODE"), "decode");
    cyc(rnd_op(), 1'b0, 1'b0, ph("EXR"), "r_exec");
    cyc(rnd_op(), 1'b0, 1'b0, ph("WBR"), "r_wb");

    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      logic [5:0] legal [8];
      legal = '{LW, SW, RT, BEQ, JMP, ADDI, ORI, SLTI};
      if ($urandom_range(0, 9) == 0) begin
        op = rnd_op();
        while (is_legal(op)) op = rnd_op();
      end else begin
        op = legal[$urandom_range(0, 7)];
      end
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style multicycle main-control FSM for the 32-bit MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back, and drives every datapath strobe and mux select. It produces the 3-bit `alu_op` consumed by the ALU-control stage: 3'b111 selects function-code decoding, and any other value passes straight through as the ALU operation. Memory accesses stall on a single ready handshake.

## Interface
- No parameters.
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  6  IR[31:26]; sampled only in DECODE, EXEC_I and the dispatch from MEM_ADDR.
- `mem_ready`  in  1  memory accepted/completed the access this cycle.
- `pc_write`, `pc_write_cond`, `i_or_d`, `mem_read`, `mem_write`, `ir_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a`  out  1 each  standard multicycle strobes and selects.
- `alu_src_b`  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `pc_source`  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- `alu_op`  out  3  ADD 000, OR 001, SLT 011, SUB 101, RTYPE 111.
- `illegal_op`  out  1  sticky illegal-opcode flag (see Configuration).

## Operation
- Supported opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, ori 001101, slti 001010. Any other opcode is illegal.
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, JUMP, HALT.
- FETCH: mem_read=1, src_a=0, src_b=01, alu_op=ADD, pc_source=00. ir_write and pc_write equal mem_ready. Go to DECODE when mem_ready=1; otherwise hold.
- DECODE: src_a=0, src_b=11, alu_op=ADD. Dispatch as follows: lw/sw to MEM_ADDR, R to EXEC_R, addi/ori/slti to EXEC_I, beq to BRANCH, j to JUMP, illegal per Configuration.
- MEM_ADDR: src_a=1, src_b=10, ADD. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready, then go to FETCH.
- EXEC_R: src_a=1, src_b=00, alu_op=RTYPE, then go to WB_R.
- WB_R: reg_write=1, reg_dst=1, then go to FETCH.
- EXEC_I: src_a=1, src_b=10. alu_op is ADD for addi, OR for ori, SLT for slti. Then go to WB_I.
- WB_I: reg_write=1, reg_dst=0, then go to FETCH.
- BRANCH: src_a=1, src_b=00, SUB, pc_write_cond=1, pc_source=01, then go to FETCH.
- JUMP: pc_write=1, pc_source=10, then go to FETCH.
- HALT: all strobes 0. Leaves only on reset.
- Any strobe or select not listed for a state is 0; alu_op not listed is ADD.

## Timing
- Outputs are combinational from the state register. The only exception is FETCH ir_write/pc_write, which are qualified by mem_ready.
- Reset: the state register loads FETCH and illegal_op clears to 0. Outputs on the first cycle after reset are therefore the FETCH values: mem_read=1, src_b=01, alu_op=000, and ir_write=pc_write=mem_ready.
- Reset has priority over every transition. Reset asserted mid-instruction (including during a stalled MEM_RD/MEM_WR) abandons that instruction with no further strobes.
- Cycle counts with zero wait states: lw 5, sw 4, R 4, I-ALU 4, beq 3, j 3. Each cycle mem_ready is low in FETCH/MEM_RD/MEM_WR adds exactly one cycle.
- mem_read/mem_write stay asserted throughout a stall. Write-enables (reg_write, ir_write, pc_write) never pulse more than once per instruction.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined: an illegal opcode in DECODE goes to HALT and sets illegal_op (sticky until reset).
- Not defined: an illegal opcode returns DECODE to FETCH as a NOP, illegal_op is tied to 0, and the HALT state is not generated.

## Structure
- Package `mips_ctrl_pkg` holds the state enum, opcode constants, and the ALU-op codes (ALUOP_ADD/OR/SLT/SUB/RTYPE) shared with the ALU-control stage.
- One sub-module, `opcode_class_decode`, maps opcode to one-hot class (rtype, load, store, branch, jump, imm_alu, illegal) plus the immediate alu_op.

## Test plan
- Reset then lw with mem_ready always 1 gives FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, FETCH: exactly 5 cycles, and reg_write=1 with mem_to_reg=1 only in cycle 5.
- R-type gives alu_op=111 in EXEC_R only. WB_R has reg_dst=1 and reg_write=1. Total 4 cycles.
- sw with mem_ready low 3 cycles in MEM_WR holds mem_write=1 for 4 cycles, then returns to FETCH with no reg_write.
- beq shows alu_op=101, pc_write_cond=1, pc_source=01 in cycle 3. ori shows alu_op=001 and slti shows alu_op=011 in EXEC_I.
- Opcode 111111 with the macro defined enters HALT and illegal_op=1 until reset. Without the macro it is a 2-cycle NOP and illegal_op=0.
- Reset asserted during a MEM_RD stall means the next cycle is FETCH and neither reg_write nor mem_to_reg is ever asserted.
